// File: rtl/baud_det_pkg.sv
// baud_det_pkg: shared types and constants for the auto-baud detector
package baud_det_pkg;
    typedef enum logic [2:0] {
        IDLE,
        WAIT_HI,
        WAIT_FALL,
        START_BIT,
        MEAS,
        CHECK
    } state_t;
    localparam logic [7:0] SYNC_CHAR = 8'h55;
    localparam int FALLS_PER_CHAR = 5;
    localparam int BITS_MEASURED = 8;
endpackage

// File: rtl/baud_det_if.sv
// baud_det_if: control, serial line and result signals of the auto-baud detector
interface baud_det_if;
    logic start;
    logic rx;
    logic [15:0] mod_m;
    logic mod_m_vld;
    logic locked;
    logic err;
    logic busy;
    modport master (output start, rx, input mod_m, mod_m_vld, locked, err, busy);
    modport slave (input start, rx, output mod_m, mod_m_vld, locked, err, busy);
endinterface

// File: rtl/baud_det_rx_sync.sv
// rx_sync_edge: 2-flop synchronizer for rx plus registered fall/rise pulses
module rx_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rx_s,
    output logic fall,
    output logic rise
);
    logic s1;
    logic s_prev;
    // flops reset to the idle-high level so reset never fakes an edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1     <= 1'b1;
            rx_s   <= 1'b1;
            s_prev <= 1'b1;
            fall   <= 1'b0;
            rise   <= 1'b0;
        end else begin
            s1     <= rx;
            rx_s   <= s1;
            s_prev <= rx_s;
            fall   <= s_prev & ~rx_s;
            rise   <= ~s_prev & rx_s;
        end
    end
endmodule

// File: rtl/baud_det.sv
// baud_det: measures a 0x55 sync character on rx and derives the baud divisor mod_m
module baud_det
    import baud_det_pkg::*;
#(
    parameter int CNT_W     = 24,
    parameter int OVS_LOG2  = 4,
    parameter int DEF_MOD_M = 68
) (
    input logic        clk,
    input logic        rst,
    baud_det_if.slave  bus
);
    localparam int S     = 3 + OVS_LOG2;
    localparam int RES_W = CNT_W - S + 1;
    localparam logic [CNT_W:0] HALF = (CNT_W + 1)'(2 ** (S - 1));
    localparam logic [2:0] LAST_FALL = 3'(FALLS_PER_CHAR - 1);
    state_t state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, t0, t0_n, total, total_n;
    logic [2:0] nfall, nfall_n;
    logic [15:0] mod_m_q, mod_m_n;
    logic locked_q, locked_n, vld_q, vld_n, err_q, err_n;
    logic rx_s, fall, rise;
    logic [CNT_W+3:0] t0_w, t0_x7, t0_x9, total_w;
    logic [CNT_W:0] rounded;
    logic [RES_W-1:0] res;
    logic [RES_W+15:0] res_x;
    logic too_big, pass, cnt_max;

    rx_sync_edge u_sync (
        .clk  (clk),
        .rst  (rst),
        .rx   (bus.rx),
        .rx_s (rx_s),
        .fall (fall),
        .rise (rise)
    );

    assign t0_w    = {4'b0, t0};
    assign total_w = {4'b0, total};
    assign t0_x7   = (t0_w << 2) + (t0_w << 1) + t0_w;
    assign t0_x9   = (t0_w << 3) + t0_w;
    assign rounded = {1'b0, total} + HALF;
    assign res     = RES_W'(rounded >> S);
    assign res_x   = {16'b0, res};
    assign too_big = |res_x[RES_W+15:16];
    assign pass    = (t0_x7 <= total_w) && (total_w <= t0_x9) && (res_x >= (RES_W + 16)'(2)) && !too_big;
    assign cnt_max = &cnt;

    assign bus.mod_m     = mod_m_q;
    assign bus.mod_m_vld = vld_q;
    assign bus.locked    = locked_q;
    assign bus.err       = err_q;
    assign bus.busy      = (state != IDLE);

    // state, measurement and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            nfall    <= '0;
            t0       <= '0;
            total    <= '0;
            mod_m_q  <= 16'(DEF_MOD_M);
            locked_q <= 1'b0;
            vld_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            nfall    <= nfall_n;
            t0       <= t0_n;
            total    <= total_n;
            mod_m_q  <= mod_m_n;
            locked_q <= locked_n;
            vld_q    <= vld_n;
            err_q    <= err_n;
        end
    end

    // next-state logic; start overrides everything, timeout beats edges so cnt never wraps
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        nfall_n  = nfall;
        t0_n     = t0;
        total_n  = total;
        mod_m_n  = mod_m_q;
        locked_n = locked_q;
        vld_n    = 1'b0;
        err_n    = 1'b0;
        if (bus.start) begin
            state_n = WAIT_HI;
            cnt_n   = '0;
            nfall_n = '0;
            t0_n    = '0;
            total_n = '0;
        end else begin
            case (state)
                WAIT_HI:   state_n = rx_s ? WAIT_FALL : WAIT_HI;
                WAIT_FALL: begin
                    if (fall) begin
                        state_n = START_BIT;
                        cnt_n   = '0;
                        nfall_n = 3'd1;
                    end
                end
                START_BIT: begin
                    if (cnt_max) begin
                        err_n   = 1'b1;
                        state_n = WAIT_HI;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                        if (rise) begin
                            t0_n    = cnt + 1'b1;
                            state_n = MEAS;
                        end
                    end
                end
                MEAS: begin
                    if (cnt_max) begin
                        err_n   = 1'b1;
                        state_n = WAIT_HI;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                        if (fall && nfall == LAST_FALL) begin
                            total_n = cnt + 1'b1;
                            state_n = CHECK;
                        end else if (fall) begin
                            nfall_n = nfall + 1'b1;
                        end
                    end
                end
                CHECK: begin
                    if (pass) begin
                        mod_m_n  = res_x[15:0];
                        locked_n = 1'b1;
                        vld_n    = 1'b1;
                        state_n  = IDLE;
                    end else begin
                        err_n   = 1'b1;
                        state_n = WAIT_HI;
                    end
                end
                default:   state_n = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_baud_det.sv
// tb_baud_det: scoreboard bench for baud_det with directed sync characters
module tb_baud_det;
    typedef struct packed {
        logic        is_err;
        logic [15:0] mod_m;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int failures = 0;
    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;

    baud_det_if bus ();
    baud_det_if bus2 ();

    baud_det dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    baud_det #(.CNT_W(12)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // scoreboard monitor for the default-width instance
    always @(negedge clk) begin : mon1
        exp_t e;
        if (!rst && (bus.mod_m_vld || bus.err)) begin
            check("vld_err_overlap", 32'(bus.mod_m_vld & bus.err), 0);
            if (q1.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event dut vld=%0d err=%0d mod_m=%0d", bus.mod_m_vld, bus.err, bus.mod_m);
            end else begin
                e = q1.pop_front();
                check("event_is_err", 32'(bus.err), 32'(e.is_err));
                check("event_mod_m", 32'(bus.mod_m), 32'(e.mod_m));
            end
        end
    end

    // scoreboard monitor for the 12-bit counter instance
    always @(negedge clk) begin : mon2
        exp_t e;
        if (!rst && (bus2.mod_m_vld || bus2.err)) begin
            check("vld_err_overlap2", 32'(bus2.mod_m_vld & bus2.err), 0);
            if (q2.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event dut2 vld=%0d err=%0d mod_m=%0d", bus2.mod_m_vld, bus2.err, bus2.mod_m);
            end else begin
                e = q2.pop_front();
                check("event_is_err2", 32'(bus2.err), 32'(e.is_err));
                check("event_mod_m2", 32'(bus2.mod_m), 32'(e.mod_m));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_rx(input int which, input logic v);
        if (which == 1) bus.rx = v;
        else bus2.rx = v;
    endtask

    task automatic pulse_start(input int which);
        @(negedge clk);
        if (which == 1) bus.start = 1'b1;
        else bus2.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus2.start = 1'b0;
    endtask

    task automatic send(input int which, input int p, input int start_mult);
        logic [7:0] ch;
        ch = 8'h55;
        set_rx(which, 1'b0);
        tick(p * start_mult);
        for (int i = 0; i < 8; i++) begin
            set_rx(which, ch[i]);
            tick(p);
        end
        set_rx(which, 1'b1);
        tick(p);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q1.size() != 0 || q2.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", 32'(q1.size() + q2.size()), 0);
        tick(20);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.rx = 1'b1;
        bus2.start = 1'b0;
        bus2.rx = 1'b1;
        tick(3);
        check("rst_mod_m", 32'(bus.mod_m), 68);
        check("rst_locked", 32'(bus.locked), 0);
        check("rst_vld", 32'(bus.mod_m_vld), 0);
        check("rst_err", 32'(bus.err), 0);
        check("rst_busy", 32'(bus.busy), 0);
        rst = 1'b0;
        tick(5);
        check("idle_busy", 32'(bus.busy), 0);

        pulse_start(1);
        check("armed_busy", 32'(bus.busy), 1);
        tick(5);
        q1.push_back('{1'b0, 16'd68});
        send(1, 1088, 1);
        drain();
        check("p1088_mod_m", 32'(bus.mod_m), 68);
        check("p1088_locked", 32'(bus.locked), 1);
        check("p1088_busy", 32'(bus.busy), 0);

        pulse_start(1);
        tick(5);
        q1.push_back('{1'b0, 16'd10});
        send(1, 160, 1);
        drain();
        check("p160_mod_m", 32'(bus.mod_m), 10);
        pulse_start(1);
        tick(5);
        q1.push_back('{1'b0, 16'd100});
        send(1, 1600, 1);
        drain();
        check("p1600_mod_m", 32'(bus.mod_m), 100);
        check("p1600_busy", 32'(bus.busy), 0);

        pulse_start(1);
        tick(5);
        bus.rx = 1'b0;
        tick(160);
        bus.rx = 1'b1;
        tick(160);
        bus.rx = 1'b0;
        tick(100);
        check("meas_busy", 32'(bus.busy), 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_mod_m", 32'(bus.mod_m), 68);
        check("async_rst_locked", 32'(bus.locked), 0);
        check("async_rst_vld", 32'(bus.mod_m_vld), 0);
        check("async_rst_err", 32'(bus.err), 0);
        check("async_rst_busy", 32'(bus.busy), 0);
        @(negedge clk);
        bus.rx = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(5);

        pulse_start(1);
        tick(5);
        q1.push_back('{1'b1, 16'd68});
        send(1, 1088, 2);
        drain();
        check("stretch_mod_m", 32'(bus.mod_m), 68);
        check("stretch_locked", 32'(bus.locked), 0);
        check("stretch_busy", 32'(bus.busy), 1);
        q1.push_back('{1'b0, 16'd68});
        send(1, 1088, 1);
        drain();
        check("retry_locked", 32'(bus.locked), 1);
        check("retry_busy", 32'(bus.busy), 0);

        pulse_start(1);
        tick(5);
        for (int i = 0; i < 4; i++) begin
            bus.rx = 1'(i % 2);
            tick(480);
        end
        bus.rx = 1'b0;
        tick(100);
        pulse_start(1);
        bus.rx = 1'b1;
        tick(50);
        q1.push_back('{1'b0, 16'd30});
        send(1, 480, 1);
        drain();
        check("abort_mod_m", 32'(bus.mod_m), 30);
        check("abort_locked", 32'(bus.locked), 1);

        pulse_start(2);
        tick(5);
        q2.push_back('{1'b1, 16'd68});
        bus2.rx = 1'b0;
        tick(4200);
        check("timeout_busy", 32'(bus2.busy), 1);
        check("timeout_mod_m", 32'(bus2.mod_m), 68);
        check("timeout_locked", 32'(bus2.locked), 0);
        bus2.rx = 1'b1;
        tick(20);
        drain();
        q2.push_back('{1'b0, 16'd10});
        send(2, 160, 1);
        drain();
        check("after_timeout_mod_m", 32'(bus2.mod_m), 10);
        check("after_timeout_locked", 32'(bus2.locked), 1);
        check("dut1_untouched", 32'(bus.mod_m), 30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/baud_det.md
Name: baud_det

Overview:
- Auto-baud detector: the receive-side counterpart of the baud tick generator.
- The generator turns a divisor into ticks; this block measures an incoming sync character (0x55, 8N1, LSB first) on the serial line and derives that divisor (mod_m).
- mod_m is the ticks-per-oversample value that feeds the generator's mod_m input, so the link's receiver and transmitter lock to the remote's bit rate.

Parameters:
- CNT_W, 24: width of the cycle counter; bounds the slowest measurable rate.
- OVS_LOG2, 4: log2 of the oversampling factor (4 = 16x).
- DEF_MOD_M, 68: mod_m value held after reset, before any lock.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; arms or re-arms a measurement
- rx  in  1  raw serial line, idle high; asynchronous to clk
- mod_m  out  16  measured divisor; holds the last good value
- mod_m_vld  out  1  one-cycle pulse when mod_m updates
- locked  out  1  set on first successful measurement
- err  out  1  one-cycle pulse on timeout or failed check
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: mod_m=DEF_MOD_M, locked=0, mod_m_vld=0, err=0, busy=0, state=IDLE, counters=0. Reset is asynchronous and takes effect mid-operation.
- Input conditioning: rx passes through a 2-flop synchronizer to give rx_s.
  - Registered edge detect produces fall and rise, each a one-cycle pulse.
  - A pin transition produces its pulse 3 cycles after the pin changes.
- Let S = 3 + OVS_LOG2.
- States and transitions:
  - IDLE: start -> WAIT_HI.
  - WAIT_HI: rx_s==1 -> WAIT_FALL. This guarantees measurement never begins mid-low.
  - WAIT_FALL: fall -> START_BIT; cnt<=0, nfall<=1.
  - START_BIT: cnt++; rise -> t0<=cnt+1, then MEAS.
  - MEAS: cnt++; each fall increments nfall. A fall while nfall==4 sets total<=cnt+1, then CHECK.
    - total is the cycle count between the 1st and 5th falling edge, i.e. 8 bit periods.
  - CHECK (1 cycle): compute res = (total + 2^(S-1)) >> S, i.e. round(bit_period / 2^OVS_LOG2).
    - Pass requires both 7*t0 <= total <= 9*t0 and 2 <= res <= 65535.
    - On pass, the next cycle: mod_m<=res[15:0], mod_m_vld=1, locked=1, state -> IDLE.
    - On fail: err=1, mod_m and locked unchanged, state -> WAIT_HI (automatic retry).
- Timeout: cnt reaching all-ones in START_BIT or MEAS produces err=1, state -> WAIT_HI, cnt cleared. The counter never wraps.
- start in any non-IDLE state restarts at WAIT_HI, clearing cnt, nfall, t0 and total. start wins over all other same-cycle events, including CHECK.
- locked, once set, is cleared only by rst. A later failed measurement does not clear it.
- Arithmetic widths:
  - 7*t0 and 9*t0 are computed as shift-add at CNT_W+4 bits.
  - res is computed at CNT_W-S+1 bits.
  - res > 65535 is detected from its upper bits being nonzero.
- mod_m_vld and err are never asserted in the same cycle.

Decomposition:
- Shared package:
  - state enum: IDLE, WAIT_HI, WAIT_FALL, START_BIT, MEAS, CHECK
  - SYNC_CHAR = 8'h55
  - FALLS_PER_CHAR = 5
  - BITS_MEASURED = 8
- One sub-module: rx_sync_edge (2-flop synchronizer plus registered edge detector; outputs rx_s, fall, rise).

Test Plan:
1. Reset only -> mod_m=68, locked=0, mod_m_vld=0, err=0, busy=0. Assert rst during MEAS -> same values immediately, with no clock edge required.
2. start, then 0x55 at P=1088 cycles/bit -> total=8704, mod_m=68; one mod_m_vld pulse; locked=1; busy=0 afterwards.
3. P=160 gives mod_m=10 with a vld pulse. A second start, then P=1600 gives mod_m=100 with a second vld pulse.
4. 0x55 with the start bit stretched to 2P (P=1088) -> t0=2176, total=9792 < 7*t0 -> err pulse; mod_m stays 68; busy stays 1. A subsequent clean 0x55 then locks.
5. CNT_W=12, line held low after the start bit -> err pulse at cnt=4095, state returns to WAIT_HI; mod_m and locked unchanged.
6. start re-pulsed after the 3rd falling edge, then a full 0x55 at P=480 -> mod_m=30. Exactly one vld pulse, and no contribution from the aborted character.
